// File: rtl/lpm_tbl_ctrl.sv
// Access controller for the LPM route table: arbitrates the single table request
// port between host accesses and a full-table flush engine, with ack timeout.
module lpm_tbl_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int ACK_TIMEOUT        = 15
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic                            host_req,
  input  logic                            host_wr,
  input  logic [TBL_ADDR_WIDTH-1:0]       host_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] host_wdata,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] host_rdata,
  output logic                            host_done,
  output logic                            host_err,
  input  logic                            flush_start,
  output logic                            flush_busy,
  output logic                            flush_done,
  input  logic                            stats_clr,
  output logic [31:0]                     timeout_count,
  output logic                            tbl_rd_req,
  output logic                            tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                            tbl_rd_ack,
  input  logic                            tbl_wr_ack
);

  localparam logic [7:0]                TO_LAST    = 8'(ACK_TIMEOUT - 1);
  localparam logic [TBL_ADDR_WIDTH-1:0] LAST_ENTRY = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      last_grant;   // 1 = flush was granted last
  logic                      owner_host;
  logic                      dir_wr;
  logic                      timed_out;
  logic [7:0]                wait_cnt;
  logic [TBL_ADDR_WIDTH-1:0] flush_ptr;
  logic                      grant_host;
  logic                      grant_flush;
  logic                      ack_ok;
  logic                      timeout_hit;

  always_comb begin
    state_nxt   = state;
    grant_host  = 1'b0;
    grant_flush = 1'b0;
    timeout_hit = 1'b0;
    ack_ok      = dir_wr ? tbl_wr_ack : tbl_rd_ack;
    case (state)
      S_IDLE: begin
        if (host_req && flush_busy) begin
          grant_host  = last_grant;
          grant_flush = !last_grant;
        end else begin
          grant_host  = host_req;
          grant_flush = flush_busy;
        end
        if (grant_host || grant_flush) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_ok) begin
          state_nxt = S_DONE;
        end else if (wait_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes and pulses decode directly from the state register.
  assign tbl_rd_req = (state == S_ISSUE) && !dir_wr;
  assign tbl_wr_req = (state == S_ISSUE) && dir_wr;
  assign host_done  = (state == S_DONE) && owner_host;
  assign host_err   = host_done && timed_out;
  assign flush_done = (state == S_DONE) && !owner_host && (flush_ptr == LAST_ENTRY);

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state         <= S_IDLE;
      last_grant    <= 1'b1;
      owner_host    <= 1'b0;
      dir_wr        <= 1'b0;
      timed_out     <= 1'b0;
      wait_cnt      <= 8'd0;
      flush_busy    <= 1'b0;
      flush_ptr     <= '0;
      timeout_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_host) begin
        owner_host <= 1'b1;
        dir_wr     <= host_wr;
        last_grant <= 1'b0;
      end
      if (grant_flush) begin
        owner_host <= 1'b0;
        dir_wr     <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == S_ISSUE) begin
        wait_cnt  <= 8'd0;
        timed_out <= 1'b0;
      end else if (state == S_WAIT_ACK) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) timed_out <= 1'b1;
      // A flush entry advances whether it was acked or timed out.
      if (state == S_DONE && !owner_host) begin
        flush_ptr <= flush_ptr + TBL_ADDR_WIDTH'(1);
        if (flush_ptr == LAST_ENTRY) flush_busy <= 1'b0;
      end
      if (flush_start && !flush_busy) begin
        flush_busy <= 1'b1;
        flush_ptr  <= '0;
      end
      if (stats_clr) begin
        timeout_count <= 32'd0;
      end else if (timeout_hit && timeout_count != 32'hFFFF_FFFF) begin
        timeout_count <= timeout_count + 32'd1;
      end
    end
  end

  // Address/data holding registers, loaded at grant and stable until DONE.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      tbl_rd_addr <= '0;
      tbl_wr_addr <= '0;
      tbl_wr_data <= '0;
      host_rdata  <= '0;
    end else begin
      if (grant_host) begin
        if (host_wr) begin
          tbl_wr_addr <= host_addr;
          tbl_wr_data <= host_wdata;
        end else begin
          tbl_rd_addr <= host_addr;
        end
      end
      if (grant_flush) begin
        tbl_wr_addr <= flush_ptr;
        tbl_wr_data <= '1;
      end
      if (state == S_WAIT_ACK && tbl_rd_ack && !dir_wr && owner_host) host_rdata <= tbl_rd_data;
    end
  end

endmodule

// File: tb/tb_lpm_tbl_ctrl.sv
// Directed bench for lpm_tbl_ctrl with a behavioural table model and
// scoreboards for host completions and table write strobes.
module tb_lpm_tbl_ctrl;

  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] D1   = 128'h0000_0000_0A00_0001_FFFF_FF00_0A00_0000;
  localparam logic [127:0] D2   = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] D3   = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;

  typedef struct {
    logic [127:0] rdata;
    logic         err;
  } host_exp_t;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
  } wr_exp_t;

  logic         clk = 1'b0;
  logic         AXI_RESETN;
  logic         host_req, host_wr, flush_start, stats_clr;
  logic [4:0]   host_addr;
  logic [127:0] host_wdata, host_rdata;
  logic         host_done, host_err, flush_busy, flush_done;
  logic [31:0]  timeout_count;
  logic         tbl_rd_req, tbl_wr_req;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_wr_data;
  logic [127:0] tbl_rd_data = '0;
  logic         tbl_rd_ack  = 1'b0;
  logic         tbl_wr_ack  = 1'b0;
  logic         ack_en;
  logic [127:0] mem [32];

  host_exp_t host_q [$];
  wr_exp_t   exp_wr [$];
  int        checks   = 0;
  int        failures = 0;
  logic      prev_wr  = 1'b0;
  logic      prev_rd  = 1'b0;

  lpm_tbl_ctrl #(
    .C_S_AXI_DATA_WIDTH(32),
    .TBL_ADDR_WIDTH(5),
    .ACK_TIMEOUT(15)
  ) dut (
    .AXI_ACLK(clk),
    .AXI_RESETN(AXI_RESETN),
    .host_req(host_req),
    .host_wr(host_wr),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_done(host_done),
    .host_err(host_err),
    .flush_start(flush_start),
    .flush_busy(flush_busy),
    .flush_done(flush_done),
    .stats_clr(stats_clr),
    .timeout_count(timeout_count),
    .tbl_rd_req(tbl_rd_req),
    .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr),
    .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data),
    .tbl_rd_data(tbl_rd_data),
    .tbl_rd_ack(tbl_rd_ack),
    .tbl_wr_ack(tbl_wr_ack)
  );

  always #5 clk = ~clk;

  // Table model: acknowledges one cycle after the strobe unless acks are disabled.
  always @(posedge clk) begin
    tbl_wr_ack <= ack_en && tbl_wr_req;
    tbl_rd_ack <= ack_en && tbl_rd_req;
    if (tbl_wr_req) mem[tbl_wr_addr] <= tbl_wr_data;
    if (tbl_rd_req) tbl_rd_data <= mem[tbl_rd_addr];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (tbl_wr_req) begin
      chk("wr_strobe_one_cycle", 128'(prev_wr), 128'd0);
      checks++;
      assert (exp_wr.size() != 0) else begin
        failures++;
        $error("FAIL wr_unexpected: observed addr=%0d data=%0h expected no write", tbl_wr_addr, tbl_wr_data);
      end
      if (exp_wr.size() != 0) begin
        wr_exp_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 128'(tbl_wr_addr), 128'(w.addr));
        chk("wr_data", tbl_wr_data, w.data);
      end
    end
    if (tbl_rd_req) chk("rd_strobe_one_cycle", 128'(prev_rd), 128'd0);
    if (host_done) begin
      checks++;
      assert (host_q.size() != 0) else begin
        failures++;
        $error("FAIL host_done_unexpected: observed done=1 expected 0");
      end
      if (host_q.size() != 0) begin
        host_exp_t e;
        e = host_q.pop_front();
        chk("host_rdata", host_rdata, e.rdata);
        chk("host_err", 128'(host_err), 128'(e.err));
      end
    end
    prev_wr = tbl_wr_req;
    prev_rd = tbl_rd_req;
  end

  // Called just after a falling edge; returns at the falling edge inside DONE.
  task automatic host_op(input logic wr, input logic [4:0] a, input logic [127:0] d,
                         input logic [127:0] exp_rd, input logic exp_err, input int limit,
                         output int lat, output int strobe_at);
    host_exp_t e;
    wr_exp_t   w;
    e.rdata = exp_rd;
    e.err   = exp_err;
    host_q.push_back(e);
    if (wr) begin
      w.addr = a;
      w.data = d;
      exp_wr.push_back(w);
    end
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = a;
    host_wdata = d;
    lat        = -1;
    strobe_at  = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (strobe_at < 0 && ((wr && tbl_wr_req && tbl_wr_addr == a) ||
                            (!wr && tbl_rd_req && tbl_rd_addr == a))) strobe_at = n;
      if (host_done) begin
        lat = n;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic start_flush();
    wr_exp_t w;
    flush_start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w.addr = 5'(i);
      w.data = ONES;
      exp_wr.push_back(w);
    end
  endtask

  task automatic wait_flush(input int limit, input int restart_at, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) flush_start = 1'b0;
      if (n == restart_at) flush_start = 1'b1;
      if (n == restart_at + 1) flush_start = 1'b0;
      if (flush_done) begin
        lat = n;
        break;
      end
    end
    flush_start = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_host_done"}, 128'(host_done), 128'd0);
    chk({p, "_host_err"}, 128'(host_err), 128'd0);
    chk({p, "_host_rdata"}, host_rdata, 128'd0);
    chk({p, "_flush_busy"}, 128'(flush_busy), 128'd0);
    chk({p, "_flush_done"}, 128'(flush_done), 128'd0);
    chk({p, "_tbl_rd_req"}, 128'(tbl_rd_req), 128'd0);
    chk({p, "_tbl_wr_req"}, 128'(tbl_wr_req), 128'd0);
    chk({p, "_tbl_rd_addr"}, 128'(tbl_rd_addr), 128'd0);
    chk({p, "_tbl_wr_addr"}, 128'(tbl_wr_addr), 128'd0);
    chk({p, "_tbl_wr_data"}, tbl_wr_data, 128'd0);
    chk({p, "_timeout_count"}, 128'(timeout_count), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, sa, hit;
    AXI_RESETN  = 1'b0;
    host_req    = 1'b0;
    host_wr     = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    flush_start = 1'b0;
    stats_clr   = 1'b0;
    ack_en      = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    AXI_RESETN = 1'b1;
    @(negedge clk);

    // Host write then read-back of entry 3
    host_op(1'b1, 5'd3, D1, 128'd0, 1'b0, 10, lat, sa);
    chk("wr3_latency", 128'(lat), 128'd3);
    chk("wr3_strobe_cycle", 128'(sa), 128'd1);
    @(negedge clk);
    host_op(1'b0, 5'd3, '0, D1, 1'b0, 10, lat, sa);
    chk("rd3_latency", 128'(lat), 128'd3);
    chk("rd3_strobe_cycle", 128'(sa), 128'd1);
    @(negedge clk);

    // Uncontended flush with an ignored second flush_start mid-way
    start_flush();
    wait_flush(300, 50, lat);
    chk("flush1_latency", 128'(lat), 128'd128);
    chk("flush1_entries_left", 128'(exp_wr.size()), 128'd0);
    @(negedge clk);
    chk("flush1_done_one_cycle", 128'(flush_done), 128'd0);
    chk("flush1_busy_cleared", 128'(flush_busy), 128'd0);

    // Host reads held against a running flush
    host_op(1'b1, 5'd7, D2, D1, 1'b0, 10, lat, sa);
    chk("wr7_latency", 128'(lat), 128'd3);
    @(negedge clk);
    start_flush();
    @(negedge clk);
    flush_start = 1'b0;
    repeat (59) @(negedge clk);
    chk("flush2_busy_mid", 128'(flush_busy), 128'd1);
    for (int r = 0; r < 3; r++) begin
      host_op(1'b0, 5'd7, '0, ONES, 1'b0, 12, lat, sa);
      chk("rd7_latency_le8", 128'(lat > 0 && lat <= 8), 128'd1);
      @(negedge clk);
    end
    wait_flush(300, -1, lat);
    chk("flush2_completed", 128'(lat > 0), 128'd1);
    chk("flush2_entries_left", 128'(exp_wr.size()), 128'd0);
    @(negedge clk);

    // Ack timeouts and stats clear overriding an increment
    ack_en = 1'b0;
    host_op(1'b0, 5'd5, '0, ONES, 1'b1, 30, lat, sa);
    chk("to_rd5_latency", 128'(lat), 128'd17);
    @(negedge clk);
    chk("to_count_one", 128'(timeout_count), 128'd1);
    stats_clr = 1'b1;
    host_op(1'b1, 5'd9, D3, ONES, 1'b1, 30, lat, sa);
    chk("to_wr9_latency", 128'(lat), 128'd17);
    chk("to_count_cleared", 128'(timeout_count), 128'd0);
    @(negedge clk);
    stats_clr = 1'b0;
    ack_en    = 1'b1;
    @(negedge clk);
    chk("to_count_stays_zero", 128'(timeout_count), 128'd0);

    // Reset in the middle of a flush, then a clean restart from entry 0
    start_flush();
    hit = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) flush_start = 1'b0;
      if (tbl_wr_req && tbl_wr_addr == 5'd10) begin
        hit = 1;
        break;
      end
    end
    chk("midrst_reached_entry10", 128'(hit), 128'd1);
    AXI_RESETN = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    exp_wr.delete();
    @(negedge clk);
    AXI_RESETN = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_resume", 128'(flush_busy), 128'd0);
    start_flush();
    wait_flush(300, -1, lat);
    chk("flush3_latency", 128'(lat), 128'd128);
    chk("flush3_entries_left", 128'(exp_wr.size()), 128'd0);
    @(negedge clk);
    chk("host_queue_drained", 128'(host_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpm_tbl_ctrl.md
# lpm_tbl_ctrl

Access controller for the 32-entry × 128-bit LPM route table in the router output-port-lookup pcore. It shares the table's single read/write request port between the host register interface and an internal flush engine that rewrites every entry to the invalid pattern. It converts level requests into one-cycle table strobes, tracks acknowledges with a timeout, and returns read data to the host.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, register word width; table entry is 4× this (128 bits).
- TBL_ADDR_WIDTH, 5, table address width (32 entries).
- ACK_TIMEOUT, 15, number of WAIT_ACK cycles without an acknowledge before the access aborts (1..255).

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESETN  in  1  reset. One clock; synchronous, active-low.
- host_req  in  1  level. Access request, held until host_done.
- host_wr  in  1  1 = write, 0 = read. Valid while host_req is high.
- host_addr  in  5  entry index.
- host_wdata  in  128  write data.
- host_rdata  out  128  read data. Updated on read ack; reset 0.
- host_done  out  1  one-cycle completion pulse; reset 0.
- host_err  out  1  pulses with host_done on timeout; reset 0.
- flush_start  in  1  pulse. Starts a full-table flush.
- flush_busy  out  1  high from acceptance until the last entry completes; reset 0.
- flush_done  out  1  one-cycle pulse after entry 31 completes; reset 0.
- stats_clr  in  1  clears timeout_count.
- timeout_count  out  32  saturating count of timed-out accesses; reset 0.
- tbl_rd_req / tbl_wr_req  out  1  one-cycle table strobes; reset 0.
- tbl_rd_addr / tbl_wr_addr  out  5  table addresses; reset 0.
- tbl_wr_data  out  128  table write data; reset 0.
- tbl_rd_data  in  128  table read data.
- tbl_rd_ack / tbl_wr_ack  in  1  table acknowledges.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: assert exactly one of tbl_rd_req / tbl_wr_req for one cycle.
  - WAIT_ACK: count cycles until the acknowledge.
  - DONE: emit pulses; return to IDLE.
- Strobes are never held for more than one cycle; the table writes on every cycle the strobe is high.
- Requesters: host (host_req high) and flush (flush pending with entries remaining).
- Arbitration in IDLE, round-robin per transaction:
  - A last_grant bit selects the other requester when both are pending.
  - last_grant resets to flush, so host wins the first tie.
  - With both continuously pending, host and flush entries alternate; the host waits at most one flush entry.
- Flush engine:
  - flush_start is accepted in any state when flush_busy = 0; this sets flush_busy and flush_ptr = 0.
  - flush_start while busy is ignored.
  - Each flush grant writes 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF to flush_ptr, then increments flush_ptr.
  - After entry 31 reaches DONE, flush_done pulses, flush_busy clears and flush_ptr wraps to 0.
  - A timeout during flush counts in timeout_count and the engine still advances; there is no retry.
- Host handshake:
  - Address, direction and data are captured into holding registers at grant.
  - In DONE, host_done = 1. host_rdata takes tbl_rd_data registered on tbl_rd_ack; it is unchanged on writes and timeouts.
  - The host must drop host_req by the edge ending the DONE cycle; IDLE re-samples it.
- Acknowledge rules:
  - In WAIT_ACK, only the ack matching the issued direction completes the access; the other ack is ignored.
  - An ack arriving in IDLE, ISSUE or DONE is ignored.
  - If ACK_TIMEOUT cycles pass in WAIT_ACK without a matching ack: DONE with host_err = 1 for a host access, and timeout_count increments (saturating at 32'hFFFF_FFFF).
- timeout_count update:
  - stats_clr = 1 sets timeout_count to 0; it overrides an increment in the same cycle.
- Reset: every output goes to its reset value, FSM to IDLE, flush_busy = 0, last_grant = flush. A reset mid-access drops the access with no done pulse; a partially flushed table is left as-is.

## Timing
- Grant at IDLE edge T: ISSUE strobe at T+1, ack expected at T+2, DONE (host_done/flush_done) at T+3. Host latency from host_req to host_done is 3 cycles with an idle controller.
- Back-to-back transactions: one every 4 cycles. A full uncontended flush therefore takes 128 cycles from acceptance to flush_done.
- tbl_*_addr and tbl_wr_data are stable from ISSUE through DONE.
- Timeout path: DONE at T+2+ACK_TIMEOUT.

## Test plan
- Host write addr 3, data 0x…0A000001_FFFFFF00_0A000000 -> one-cycle tbl_wr_req with addr 3 at T+1; host_done at T+3; host_err = 0.
- Host read addr 3 after that write, with the table model returning the stored value -> host_rdata equals written data at DONE; tbl_rd_req high exactly 1 cycle.
- flush_start with host idle -> 32 write strobes to addrs 0..31 in order, each data all-ones, every 4 cycles; flush_done one cycle at T+128; a second flush_start mid-flush produces no restart.
- Host read of addr 7 held high during flush -> strict alternation of flush/host grants; host_done within 8 cycles of host_req; flush still completes all 32 entries.
- Table model never acks, ACK_TIMEOUT = 15 -> host_done + host_err at T+17; timeout_count = 1. stats_clr in the same cycle as a second timeout -> count = 0.
- AXI_RESETN low mid-flush at entry 10 -> all outputs at reset values next cycle; no flush_done; a new flush_start restarts at entry 0.
